// File: rtl/mem_access_phase.sv
// mem_access_phase: multi-cycle data-memory / UART byte IO stage between execute and write-back
`ifndef OPCODE_W
`define OPCODE_W 6
`endif
`ifndef ADDR_W
`define ADDR_W 16
`endif
`ifndef REG_W
`define REG_W 32
`endif

module mem_access_phase #(
   parameter int MEM_LAT  = 2,
   parameter int IN_BYTES = 4
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [`OPCODE_W-1:0] opcode,
   input  logic [`ADDR_W-1:0]   addr,
   input  logic [`REG_W-1:0]    st_data,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [`ADDR_W-1:0]   mem_addr,
   output logic [`REG_W-1:0]    mem_wdata,
   input  logic [`REG_W-1:0]    mem_rdata,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 rx_ready,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   output logic [`REG_W-1:0]    ld_data,
   output logic                 done,
   output logic                 busy
);
   localparam logic [`OPCODE_W-1:0] OP_LW    = `OPCODE_W'h10;
   localparam logic [`OPCODE_W-1:0] OP_SW    = `OPCODE_W'h11;
   localparam logic [`OPCODE_W-1:0] OP_LWCZ  = `OPCODE_W'h12;
   localparam logic [`OPCODE_W-1:0] OP_SWCZ  = `OPCODE_W'h13;
   localparam logic [`OPCODE_W-1:0] OP_ININT = `OPCODE_W'h20;
   localparam logic [`OPCODE_W-1:0] OP_INFLT = `OPCODE_W'h21;
   localparam logic [`OPCODE_W-1:0] OP_OUT   = `OPCODE_W'h22;

   typedef enum logic [2:0] {IDLE, MEM, RX, TX, FIN} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [7:0]        tx_q, tx_d;
   logic [`REG_W-1:0] sh_q, sh_d;
   logic [`REG_W-1:0] ld_q, ld_d;

   // Memory request is issued in the start cycle itself so the read latency counts from there.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      sh_d      = sh_q;
      ld_d      = ld_q;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rx_ready  = 1'b0;
      tx_valid  = 1'b0;
      case (state_q)
         IDLE: if (start && rstn) begin
            case (opcode)
               OP_LW, OP_LWCZ: begin
                  state_d  = MEM;
                  cnt_d    = 3'(MEM_LAT);
                  mem_en   = 1'b1;
                  mem_addr = addr;
               end
               OP_SW, OP_SWCZ: begin
                  state_d   = FIN;
                  mem_en    = 1'b1;
                  mem_we    = 1'b1;
                  mem_addr  = addr;
                  mem_wdata = st_data;
               end
               OP_ININT, OP_INFLT: begin
                  state_d = RX;
                  cnt_d   = '0;
                  sh_d    = '0;
               end
               OP_OUT: begin
                  state_d = TX;
                  tx_d    = st_data[7:0];
               end
               default: state_d = FIN;
            endcase
         end
         MEM: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               ld_d    = mem_rdata;
               state_d = FIN;
            end
         end
         RX: begin
            rx_ready = rx_valid;
            if (rx_valid) begin
               sh_d  = {sh_q[`REG_W-9:0], rx_data};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'(IN_BYTES - 1)) begin
                  ld_d    = {sh_q[`REG_W-9:0], rx_data};
                  state_d = FIN;
               end
            end
         end
         TX: begin
            tx_valid = 1'b1;
            if (tx_ready) state_d = FIN;
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tx_q    <= '0;
         sh_q    <= '0;
         ld_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         sh_q    <= sh_d;
         ld_q    <= ld_d;
      end
   end

   assign tx_data = tx_q;
   assign ld_data = ld_q;
   assign done    = (state_q == FIN);
   assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_mem_access_phase.sv
// tb_mem_access_phase: scoreboard bench; stimulus pushes expected completions, a negedge monitor checks each done.
`ifndef OPCODE_W
`define OPCODE_W 6
`endif
`ifndef ADDR_W
`define ADDR_W 16
`endif
`ifndef REG_W
`define REG_W 32
`endif

module tb_mem_access_phase;
   localparam int MEM_LAT = 2;
   localparam logic [`OPCODE_W-1:0] OP_ADD   = `OPCODE_W'h00;
   localparam logic [`OPCODE_W-1:0] OP_LW    = `OPCODE_W'h10;
   localparam logic [`OPCODE_W-1:0] OP_SW    = `OPCODE_W'h11;
   localparam logic [`OPCODE_W-1:0] OP_ININT = `OPCODE_W'h20;
   localparam logic [`OPCODE_W-1:0] OP_INFLT = `OPCODE_W'h21;
   localparam logic [`OPCODE_W-1:0] OP_OUT   = `OPCODE_W'h22;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b0;
   logic                 start = 1'b0;
   logic [`OPCODE_W-1:0] opcode = '0;
   logic [`ADDR_W-1:0]   addr = '0;
   logic [`REG_W-1:0]    st_data = '0;
   logic                 mem_en, mem_we;
   logic [`ADDR_W-1:0]   mem_addr;
   logic [`REG_W-1:0]    mem_wdata, mem_rdata;
   logic                 rx_valid = 1'b0;
   logic [7:0]           rx_data = '0;
   logic                 rx_ready, tx_valid;
   logic [7:0]           tx_data;
   logic                 tx_ready = 1'b0;
   logic [`REG_W-1:0]    ld_data;
   logic                 done, busy;

   mem_access_phase #(.MEM_LAT(MEM_LAT), .IN_BYTES(4)) dut (
      .clk(clk), .rstn(rstn), .start(start), .opcode(opcode), .addr(addr), .st_data(st_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .ld_data(ld_data), .done(done), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mem [0:255] = '{8'h10: 32'hDEADBEEF, default: 32'h0};
   logic [31:0] rpipe [0:MEM_LAT-1] = '{default: 32'h0};
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      rpipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 32'hBAD0BAD0;
      for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign mem_rdata = rpipe[MEM_LAT-1];

   typedef struct {
      string       name;
      logic [31:0] ld;
      int          lat;
      int          en;
      int          we;
      int          rx;
      int          hs;
      int          tv;
      logic [7:0]  tx;
      int          c0;
   } exp_t;

   exp_t q[$];
   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   initial begin
      int en_c, we_c, rx_c, hs_c, tv_c, tx_bad;
      exp_t e;
      en_c = 0; we_c = 0; rx_c = 0; hs_c = 0; tv_c = 0; tx_bad = 0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            en_c = 0; we_c = 0; rx_c = 0; hs_c = 0; tv_c = 0; tx_bad = 0;
         end else begin
            en_c += int'(mem_en);
            we_c += int'(mem_we);
            rx_c += int'(rx_ready);
            hs_c += int'(tx_valid && tx_ready);
            tv_c += int'(tx_valid);
            if (tx_valid && q.size() > 0 && tx_data !== q[0].tx) tx_bad++;
            if (done) begin
               if (q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_done: got done=1 at cycle %0d expected no completion", cyc);
               end else begin
                  e = q.pop_front();
                  chk({e.name, "_ld_data"}, ld_data, e.ld);
                  chk({e.name, "_latency"}, 32'(cyc - e.c0), 32'(e.lat));
                  chk({e.name, "_mem_en_cycles"}, 32'(en_c), 32'(e.en));
                  chk({e.name, "_mem_we_cycles"}, 32'(we_c), 32'(e.we));
                  chk({e.name, "_rx_ready_cycles"}, 32'(rx_c), 32'(e.rx));
                  chk({e.name, "_tx_handshakes"}, 32'(hs_c), 32'(e.hs));
                  chk({e.name, "_tx_valid_cycles"}, 32'(tv_c), 32'(e.tv));
                  chk({e.name, "_tx_data_unstable"}, 32'(tx_bad), 32'd0);
               end
               en_c = 0; we_c = 0; rx_c = 0; hs_c = 0; tv_c = 0; tx_bad = 0;
            end
         end
      end
   end

   task automatic issue(input string nm, input logic [`OPCODE_W-1:0] op, input logic [`ADDR_W-1:0] a,
                        input logic [31:0] d, input logic push, input logic [31:0] ld, input int lat,
                        input int en, input int we, input int rx, input int hs, input int tv, input logic [7:0] tx);
      exp_t e;
      start = 1'b1; opcode = op; addr = a; st_data = d;
      if (push) begin
         e = '{nm, ld, lat, en, we, rx, hs, tv, tx, cyc};
         q.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic rx_byte(input logic v, input logic [7:0] b);
      rx_valid = v; rx_data = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || q.size() != 0) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      tests++;
      if (n >= 100) begin
         fails++;
         $display("FAIL idle_timeout: busy=%0b pending=%0d expected idle with none pending", busy, q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      start = 1'b1; opcode = OP_SW; addr = 16'h0040; st_data = 32'hFFFF_FFFF; rx_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_mem_en", {31'b0, mem_en}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_rx_ready", {31'b0, rx_ready}, 32'd0);
      chk("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
      chk("reset_ld_data", ld_data, 32'd0);
      chk("reset_tx_data", {24'b0, tx_data}, 32'd0);
      start = 1'b0; rx_valid = 1'b0; st_data = '0;
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      issue("lw", OP_LW, 16'h0010, 32'h0, 1'b1, 32'hDEADBEEF, 3, 1, 0, 0, 0, 0, 8'h00);
      wait_idle();

      issue("sw", OP_SW, 16'h0020, 32'h12345678, 1'b1, 32'hDEADBEEF, 1, 1, 1, 0, 0, 0, 8'h00);
      wait_idle();
      chk("sw_mem_contents", mem[8'h20], 32'h12345678);

      issue("inint", OP_ININT, 16'h0, 32'h0, 1'b1, 32'h0000012C, 6, 0, 0, 4, 0, 0, 8'h00);
      rx_byte(1'b1, 8'h00);
      rx_byte(1'b1, 8'h00);
      rx_byte(1'b0, 8'hEE);
      rx_byte(1'b1, 8'h01);
      rx_byte(1'b1, 8'h2C);
      wait_idle();

      issue("out", OP_OUT, 16'h0, 32'h00000141, 1'b1, 32'h0000012C, 7, 0, 0, 0, 1, 6, 8'h41);
      repeat (5) begin
         @(posedge clk); #1;
      end
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
      wait_idle();

      issue("inflt_aborted", OP_INFLT, 16'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 0, 0, 0, 8'h00);
      rx_byte(1'b1, 8'h3F);
      rx_byte(1'b1, 8'h80);
      rstn = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_ld_data", ld_data, 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      issue("inflt", OP_INFLT, 16'h0, 32'h0, 1'b1, 32'h3F800000, 5, 0, 0, 4, 0, 0, 8'h00);
      rx_byte(1'b1, 8'h3F);
      rx_byte(1'b1, 8'h80);
      rx_byte(1'b1, 8'h00);
      rx_byte(1'b1, 8'h00);
      wait_idle();

      issue("lw_busy", OP_LW, 16'h0010, 32'h0, 1'b1, 32'hDEADBEEF, 3, 1, 0, 0, 0, 0, 8'h00);
      issue("sw_ignored", OP_SW, 16'h0030, 32'hAAAA5555, 1'b0, 32'h0, 0, 0, 0, 0, 0, 0, 8'h00);
      wait_idle();
      chk("ignored_sw_mem", mem[8'h30], 32'h0);
      rx_valid = 1'b1; rx_data = 8'h99;
      issue("add", OP_ADD, 16'h0010, 32'h5, 1'b1, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 8'h00);
      rx_valid = 1'b0;
      wait_idle();

      issue("add_fin", OP_ADD, 16'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 8'h00);
      issue("add_in_fin", OP_ADD, 16'h0, 32'h0, 1'b0, 32'h0, 0, 0, 0, 0, 0, 0, 8'h00);
      wait_idle();
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("final_busy", {31'b0, busy}, 32'd0);
      chk("final_pending", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_access_phase.md
Name: mem_access_phase

Overview:
- Multi-cycle memory/IO stage of the core; sits between execute and write-back.
- Performs data-memory loads/stores (LW, SW, LWCZ, SWCZ), input reads (ININT, INFLT) from the UART receive byte stream, and byte output (OUT) to the UART transmitter.
- Presents a stable ld_data to write-back with a one-cycle done pulse.
- All other opcodes pass through in one cycle.

Parameters:
- MEM_LAT, 2, data-memory read latency in cycles from mem_en to valid mem_rdata (1..7).
- IN_BYTES, 4, bytes assembled per ININT/INFLT word (fixed 4 for 32-bit REG_W).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latch opcode/addr/data and begin
- opcode  in  `OPCODE_W  instruction opcode
- addr  in  `ADDR_W  word address from execute
- st_data  in  `REG_W  store / OUT data
- mem_en  out  1  data-memory enable
- mem_we  out  1  data-memory write enable
- mem_addr  out  `ADDR_W  data-memory address
- mem_wdata  out  `REG_W  data-memory write data
- mem_rdata  in  `REG_W  data-memory read data
- rx_valid  in  1  receive byte available
- rx_data  in  8  receive byte
- rx_ready  out  1  receive byte consumed this cycle
- tx_valid  out  1  transmit byte offered
- tx_data  out  8  transmit byte
- tx_ready  in  1  transmitter accepts byte
- ld_data  out  `REG_W  load/input result to write-back
- done  out  1  one-cycle completion pulse
- busy  out  1  high from cycle after start until done

Behaviour:
- Reset (rstn=0 at posedge): state IDLE; all outputs 0; byte counter 0; latched regs 0. Takes priority over start; reset mid-operation aborts without completing, no done pulse.
- States: IDLE, MEM, RX, TX, FIN.
- IDLE + start, by opcode:
  - LW/LWCZ -> MEM. mem_en=1, mem_we=0, mem_addr=addr for exactly the first cycle; wait counter loaded with MEM_LAT.
  - SW/SWCZ -> FIN. mem_en=1, mem_we=1, mem_addr=addr, mem_wdata=st_data for one cycle.
  - ININT/INFLT -> RX. Counter=0, ld_data shift register cleared.
  - OUT -> TX. tx_data=st_data[7:0].
  - Any other opcode -> FIN, no side effects.
- start while busy=1 is ignored.
- MEM: counter decrements each cycle. When it reaches 0, ld_data<=mem_rdata -> FIN. LW with MEM_LAT=2 raises done 3 cycles after start.
- RX:
  - rx_ready = rx_valid (combinational).
  - On each accepted byte: ld_data<={ld_data[23:0],rx_data}, i.e. big-endian, first byte ends in [31:24].
  - After IN_BYTES bytes -> FIN.
  - rx_valid gaps stall indefinitely with no timeout.
- TX:
  - tx_valid=1, tx_data held stable until tx_ready=1.
  - Handshake cycle (tx_valid&tx_ready) -> FIN; tx_valid drops the next cycle.
- FIN: done=1 for one cycle -> IDLE.
  - ld_data holds its value until the next load/input completes.
  - Stores, OUT and pass-through leave ld_data unchanged.
- busy=1 in MEM/RX/TX/FIN.
- done and start in the same cycle: done completes; start is accepted only in IDLE.
- Address wrap: mem_addr passed unmodified; no bounds check.

Test Plan:
1. LW addr=0x10, memory model MEM_LAT=2 returning 0xDEADBEEF -> mem_en pulse 1 cycle with mem_we=0; done at start+3; ld_data=0xDEADBEEF.
2. SW addr=0x20, st_data=0x12345678 -> single cycle mem_en=mem_we=1, mem_wdata=0x12345678; done at start+1; ld_data unchanged.
3. ININT, rx bytes 0x00,0x00,0x01,0x2C, one idle gap after byte 2 -> rx_ready high exactly 4 cycles; ld_data=0x0000012C; done the cycle after the 4th byte.
4. OUT st_data=0x141, tx_ready held low 5 cycles -> tx_valid=1, tx_data=0x41 stable throughout; single handshake; done next cycle.
5. rstn=0 during RX after 2 bytes, then INFLT with bytes 0x3F,0x80,0x00,0x00 -> no done from the aborted op; ld_data=0x3F800000.
6. start pulse during busy LW, then opcode ADD after IDLE -> second start ignored; ADD gives done at start+1, no mem/rx/tx activity.
